// File: rtl/intr_aggregator.sv
// Interrupt aggregator: per-source level/edge gateway with pending and in-service
// tracking, fixed lowest-index-wins priority, and claim/complete handshake.
module intr_aggregator #(
    parameter int NumSrc = 32,
    parameter int IdW    = $clog2(NumSrc + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] intr_src_i,
    input  logic [NumSrc-1:0] en_i,
    input  logic [NumSrc-1:0] edge_i,
    output logic              irq_o,
    output logic [IdW-1:0]    irq_id_o,
    input  logic              claim_i,
    input  logic              complete_i,
    input  logic [IdW-1:0]    complete_id_i
);

    logic [NumSrc-1:0] pending_q;
    logic [NumSrc-1:0] pending_d;
    logic [NumSrc-1:0] in_service_q;
    logic [NumSrc-1:0] in_service_d;
    logic [NumSrc-1:0] src_q;

    logic [NumSrc-1:0] event_s;
    logic [NumSrc-1:0] set_s;
    logic [NumSrc-1:0] active_s;
    logic [NumSrc-1:0] claim_vec_s;
    logic [NumSrc-1:0] comp_vec_s;
    logic [IdW-1:0]    sel_id_s;
    logic              found_s;

    // Gateway: events only register against pre-edge state, so a busy source drops them.
    always_comb begin
        event_s = (edge_i & intr_src_i & ~src_q) | (~edge_i & intr_src_i);
        set_s   = event_s & ~pending_q & ~in_service_q;
    end

    // Priority pick: the first enabled pending source from bit 0 upward wins.
    always_comb begin
        active_s = pending_q & en_i;
        sel_id_s = {IdW{1'b0}};
        found_s  = 1'b0;
        for (int k = 0; k < NumSrc; k++) begin
            if (active_s[k] && !found_s) begin
                sel_id_s = IdW'(k + 1);
                found_s  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Claim/complete decode; IDs outside 1..NumSrc match no bit and are ignored.
    always_comb begin
        claim_vec_s = {NumSrc{1'b0}};
        comp_vec_s  = {NumSrc{1'b0}};
        for (int k = 0; k < NumSrc; k++) begin
            claim_vec_s[k] = claim_i && (sel_id_s == IdW'(k + 1));
            comp_vec_s[k]  = complete_i && (complete_id_i == IdW'(k + 1));
        end
    end

    // Next state: completion is applied before the claim so claim k with complete k keeps k in service.
    always_comb begin
        pending_d    = (pending_q | set_s) & ~claim_vec_s;
        in_service_d = (in_service_q & ~comp_vec_s) | claim_vec_s;
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q    <= {NumSrc{1'b0}};
            in_service_q <= {NumSrc{1'b0}};
            src_q        <= {NumSrc{1'b0}};
        end else begin
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            src_q        <= intr_src_i;
        end
    end

    assign irq_id_o = sel_id_s;
    assign irq_o    = (sel_id_s != {IdW{1'b0}});

endmodule

// File: tb/tb_intr_aggregator.sv
// Directed bench for intr_aggregator: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_intr_aggregator;

    localparam int NumSrc = 32;
    localparam int IdW    = 6;

    logic              clk;
    logic              rst_n;
    logic [NumSrc-1:0] src;
    logic [NumSrc-1:0] en;
    logic [NumSrc-1:0] edg;
    logic              irq;
    logic [IdW-1:0]    irq_id;
    logic              claim;
    logic              complete;
    logic [IdW-1:0]    complete_id;

    int total = 0;
    int bad   = 0;

    intr_aggregator #(.NumSrc(NumSrc), .IdW(IdW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .intr_src_i   (src),
        .en_i         (en),
        .edge_i       (edg),
        .irq_o        (irq),
        .irq_id_o     (irq_id),
        .claim_i      (claim),
        .complete_i   (complete),
        .complete_id_i(complete_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic exp_irq, input logic [IdW-1:0] exp_id);
        chk({tag, "_irq"}, {63'd0, irq}, {63'd0, exp_irq});
        chk({tag, "_id"}, {58'd0, irq_id}, {58'd0, exp_id});
    endtask

    task automatic do_claim();
        claim = 1'b1;
        tick();
        claim = 1'b0;
    endtask

    task automatic do_complete(input logic [IdW-1:0] id);
        complete    = 1'b1;
        complete_id = id;
        tick();
        complete    = 1'b0;
        complete_id = 6'd0;
    endtask

    task automatic pulse(input int k);
        src[k] = 1'b1;
        tick();
        src[k] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; src = 32'd0; en = 32'hFFFF_FFFF; edg = 32'd0;
        claim = 1'b0; complete = 1'b0; complete_id = 6'd0;
        tick(); tick();
        chk_out("reset", 1'b0, 6'd0);
        chk("reset_pend", {32'd0, dut.pending_q}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk_out("idle", 1'b0, 6'd0);

        // Edge source 5: pulse -> id 5, claim -> idle.
        edg[4] = 1'b1;
        pulse(4);
        chk_out("e5_pend", 1'b1, 6'd5);
        do_claim();
        chk_out("e5_claim", 1'b0, 6'd0);
        do_complete(6'd5);
        tick();
        chk_out("e5_done", 1'b0, 6'd0);

        // Sources 3 and 7; claim 7 together with complete 3.
        edg[2] = 1'b1; edg[6] = 1'b1;
        src[2] = 1'b1; src[6] = 1'b1;
        tick();
        src[2] = 1'b0; src[6] = 1'b0;
        chk_out("p37", 1'b1, 6'd3);
        do_claim();
        chk_out("p37_claim3", 1'b1, 6'd7);
        claim = 1'b1; complete = 1'b1; complete_id = 6'd3;
        tick();
        claim = 1'b0; complete = 1'b0; complete_id = 6'd0;
        chk_out("claim7_comp3", 1'b0, 6'd0);
        chk("insvc_only7", {32'd0, dut.in_service_q}, 64'h40);
        pulse(2);
        chk_out("src3_repend", 1'b1, 6'd3);
        do_claim();
        do_complete(6'd3);
        do_complete(6'd7);
        chk_out("p37_done", 1'b0, 6'd0);

        // Level source 2 held high re-pends after completion.
        src[1] = 1'b1;
        tick();
        chk_out("l2_pend", 1'b1, 6'd2);
        do_claim();
        chk_out("l2_claim", 1'b0, 6'd0);
        do_complete(6'd2);
        chk_out("l2_compedge", 1'b0, 6'd0);
        tick();
        chk_out("l2_repend", 1'b1, 6'd2);
        do_claim();
        src[1] = 1'b0;
        tick();
        do_complete(6'd2);
        tick();
        chk_out("l2_low", 1'b0, 6'd0);

        // Edge source 1 in service drops further pulses.
        edg[0] = 1'b1;
        pulse(0);
        chk_out("e1_pend", 1'b1, 6'd1);
        do_claim();
        pulse(0); tick();
        pulse(0); tick();
        chk_out("e1_busy", 1'b0, 6'd0);
        do_complete(6'd1);
        tick();
        chk_out("e1_dropped", 1'b0, 6'd0);

        // Enable masks but keeps pending; reset clears everything.
        edg[3] = 1'b1;
        pulse(3);
        chk_out("s4_pend", 1'b1, 6'd4);
        en[3] = 1'b0;
        #1;
        chk_out("s4_masked", 1'b0, 6'd0);
        tick(); tick();
        chk_out("s4_held", 1'b0, 6'd0);
        en[3] = 1'b1;
        #1;
        chk_out("s4_unmask", 1'b1, 6'd4);
        rst_n = 1'b0;
        #1;
        chk_out("midrst", 1'b0, 6'd0);
        src[0] = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("postrst_edge", 1'b1, 6'd1);
        src[0] = 1'b0;
        do_claim();
        do_complete(6'd1);
        chk_out("postrst_clean", 1'b0, 6'd0);

        // Null claim and out-of-range completion leave state unchanged.
        edg[5] = 1'b1; edg[8] = 1'b1;
        pulse(5);
        do_claim();
        en[8] = 1'b0;
        pulse(8);
        chk_out("null_pre", 1'b0, 6'd0);
        claim = 1'b1; complete = 1'b1; complete_id = 6'd33;
        tick();
        complete_id = 6'd0;
        tick();
        claim = 1'b0; complete = 1'b0;
        chk("null_pend", {32'd0, dut.pending_q}, 64'h100);
        chk("null_insvc", {32'd0, dut.in_service_q}, 64'h20);
        en[8] = 1'b1;
        #1;
        chk_out("null_unmask", 1'b1, 6'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_aggregator.md
INTR_AGGREGATOR -- requirements
Module: intr_aggregator

Interface
REQ-001 Parameter NumSrc, default 32, number of interrupt sources (legal range 1..63); source k occupies bit k-1, and ID 0 means "none".
REQ-002 Derived parameter IdW, default $clog2(NumSrc+1), width of every ID port.
REQ-003 clk_i  input  1  system clock; the block has one clock.
REQ-004 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 intr_src_i  input  NumSrc  flattened peripheral interrupt lines, synchronous to clk_i.
REQ-006 en_i  input  NumSrc  per-source enable mask.
REQ-007 edge_i  input  NumSrc  per-source mode: 1 = rising-edge, 0 = level-high.
REQ-008 irq_o  output  1  interrupt request to the CPU.
REQ-009 irq_id_o  output  IdW  ID of the highest-priority pending, enabled source; 0 if none.
REQ-010 claim_i  input  1  single-cycle claim of the ID currently on irq_id_o.
REQ-011 complete_i  input  1  single-cycle completion strobe.
REQ-012 complete_id_i  input  IdW  ID being completed, qualified by complete_i.

Function
REQ-013 State per source: pending, in_service, and src_q (intr_src_i delayed by one cycle); all are flops.
REQ-014 Gateway, level mode: if intr_src_i[k] is 1 and source k is neither pending nor in_service, pending[k] sets at the next edge.
REQ-015 Gateway, edge mode: if intr_src_i[k] & ~src_q[k] and source k is neither pending nor in_service, pending[k] sets at the next edge.
REQ-016 An edge arriving while a source is pending or in_service is dropped; no counting or queueing.
REQ-017 Level mode: a line still high after completion re-pends one cycle after the completion edge.
REQ-018 en_i gates only selection: pending is set and held regardless of en_i, and clearing en_i masks but does not clear pending.
REQ-019 Selection is combinational from the pending and en_i registers: the lowest source index wins; irq_id_o = index+1; irq_o = (irq_id_o != 0).
REQ-020 Latency: a source event sampled at edge N gives irq_o/irq_id_o valid in the cycle after edge N (one cycle).
REQ-021 There is no combinational path from intr_src_i, claim_i or complete_* to irq_o or irq_id_o.
REQ-022 Claim effect: claim_i=1 with irq_id_o=k≠0 clears pending[k] and sets in_service[k] at the next edge.
REQ-023 Claim with irq_id_o=0 is ignored.
REQ-024 Complete: complete_i=1 with complete_id_i=k in 1..NumSrc clears in_service[k] at the next edge.
REQ-025 Complete with ID 0, ID >NumSrc, or an ID not in service has no effect.
REQ-026 Simultaneous claim k and complete j≠k: both take effect in the same edge.
REQ-027 Source event on k in the same cycle as complete k: the event is evaluated against pre-edge state, so it is dropped; a level source re-pends per REQ-017.
REQ-028 Source event on k in the same cycle as claim k: the claim applies and the event is dropped.
REQ-029 Up to NumSrc sources may be in_service concurrently; priority ignores in_service state.

Reset
REQ-030 While rst_ni=0, pending, in_service and src_q are 0, irq_o=0 and irq_id_o=0.
REQ-031 Reset mid-operation discards all pending and in-service state.
REQ-032 Because src_q resets to 0, an edge-mode line high in the first post-reset cycle counts as a rising edge.

Verification
REQ-033 Edge-mode source 5 enabled, single-cycle pulse on intr_src_i[4] -> cycle after the edge irq_o=1, irq_id_o=5; claim -> irq_o=0 next cycle.
REQ-034 Sources 3 and 7 pending and enabled -> irq_id_o=3; claim -> irq_id_o=7 next cycle; complete 3 -> no change in irq_id_o.
REQ-035 Level source 2 held high: claim, then complete_id_i=2 -> irq_id_o=2 again one cycle after the completion edge; line low before complete -> irq_o stays 0.
REQ-036 Edge source 1 in_service receives two further pulses, then is completed -> irq_o stays 0 (both pulses dropped).
REQ-037 Source 4 pending, en_i[3] cleared -> irq_o=0; en_i[3] set again -> irq_id_o=4 with no new event; assert rst_ni=0 -> all outputs 0.
REQ-038 claim_i with irq_id_o=0, and complete_id_i=NumSrc+1 -> no state change (pending and in_service vectors unchanged).
